keypad_operand_entry: RTL

Parametrised keypad operand-entry engine for the multiplier front end; successor to the fixed two-operand, 8-bit capture stage. Consumes the one-cycle-per-press decoded key code produced by the debounce and decode path. Assembles decimal digits into NUM_OPS signed two's-complement operands, with per-operand sign, clear and overflow rejection, then presents them to the multiplier datapath through a valid/ready handshake.

---
 rtl/keypad_operand_entry.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/keypad_operand_entry.sv
// Keypad operand-entry engine: assembles decimal key presses into NUM_OPS signed operands
// and hands them over on a valid/ready handshake. Optional backspace editing: KEYPAD_BACKSPACE_EN.
module keypad_operand_entry #(
  parameter int NUM_OPS    = 2,
  parameter int MAG_W      = 7,
  parameter int MAX_DIGITS = 3,
  localparam int OP_W      = MAG_W + 1,
  localparam int IDX_W     = $clog2(NUM_OPS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    ops_ready,
  output logic [NUM_OPS*OP_W-1:0] ops_o,
  output logic                    ops_valid,
  output logic [IDX_W-1:0]        op_idx_o,
  output logic [3:0]              digit_cnt_o,
  output logic [MAG_W-1:0]        entry_mag_o,
  output logic                    sign_o,
  output logic                    ovf_o
);

  localparam int WIDE = MAG_W + 4;
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_SIGN  = 4'hD;

  typedef enum logic {ENTRY, DONE} state_t;

  state_t          state;
  logic [OP_W-1:0] slots [NUM_OPS];
  logic [WIDE-1:0] next_mag;
  logic [OP_W-1:0] enter_val;

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_pack
    assign ops_o[k*OP_W +: OP_W] = slots[k];
  end

  // Wide enough that mag*10+9 never wraps, so the range check is exact.
  assign next_mag  = WIDE'(entry_mag_o) * WIDE'(10) + WIDE'(key_code);
  assign enter_val = sign_o ? -{1'b0, entry_mag_o} : {1'b0, entry_mag_o};

`ifdef KEYPAD_BACKSPACE_EN
  logic [OP_W-1:0]  prev_val;
  logic [MAG_W-1:0] prev_mag;

  function automatic logic [3:0] dec_digits(input logic [MAG_W-1:0] v);
    logic [3:0]      n;
    longint unsigned p;
    n = 4'd0;
    p = 1;
    for (int i = 0; i < 10; i++) begin
      if (64'(v) >= p) n = 4'(i + 1);
      p = p * 10;
    end
    return n;
  endfunction

  always_comb begin
    prev_val = '0;
    for (int k = 0; k < NUM_OPS - 1; k++)
      if (op_idx_o == IDX_W'(k + 1)) prev_val = slots[k];
    prev_mag = MAG_W'(prev_val[OP_W-1] ? -prev_val : prev_val);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY;
      op_idx_o    <= '0;
      digit_cnt_o <= '0;
      entry_mag_o <= '0;
      sign_o      <= 1'b0;
      ops_valid   <= 1'b0;
      ovf_o       <= 1'b0;
      for (int k = 0; k < NUM_OPS; k++) slots[k] <= '0;
    end else begin
      ovf_o <= 1'b0;
      case (state)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (digit_cnt_o == 4'(MAX_DIGITS) || next_mag > WIDE'((1 << MAG_W) - 1)) begin
                ovf_o <= 1'b1;
              end else begin
                entry_mag_o <= next_mag[MAG_W-1:0];
                digit_cnt_o <= digit_cnt_o + 4'd1;
              end
            end else begin
              case (key_code)
                KEY_SIGN: sign_o <= ~sign_o;
                KEY_ENTER: begin
                  for (int k = 0; k < NUM_OPS; k++)
                    if (op_idx_o == IDX_W'(k)) slots[k] <= enter_val;
                  entry_mag_o <= '0;
                  digit_cnt_o <= '0;
                  sign_o      <= 1'b0;
                  if (op_idx_o == IDX_W'(NUM_OPS - 1)) begin
                    state     <= DONE;
                    ops_valid <= 1'b1;
                  end else begin
                    op_idx_o <= op_idx_o + IDX_W'(1);
                  end
                end
                KEY_CLEAR: begin
                  entry_mag_o <= '0;
                  digit_cnt_o <= '0;
                  sign_o      <= 1'b0;
                  op_idx_o    <= '0;
                  for (int k = 0; k < NUM_OPS; k++) slots[k] <= '0;
                end
`ifdef KEYPAD_BACKSPACE_EN
                4'hB: begin
                  if (digit_cnt_o != 4'd0) begin
                    entry_mag_o <= MAG_W'(WIDE'(entry_mag_o) / WIDE'(10));
                    digit_cnt_o <= digit_cnt_o - 4'd1;
                  end else if (op_idx_o != '0) begin
                    // Step back into the previous operand and reopen it for editing.
                    op_idx_o    <= op_idx_o - IDX_W'(1);
                    entry_mag_o <= prev_mag;
                    sign_o      <= prev_val[OP_W-1];
                    digit_cnt_o <= dec_digits(prev_mag);
                    for (int k = 0; k < NUM_OPS - 1; k++)
                      if (op_idx_o == IDX_W'(k + 1)) slots[k] <= '0;
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        end
        DONE: begin
          // A transfer takes priority over any key arriving on the same edge.
          if (ops_valid && ops_ready) begin
            state     <= ENTRY;
            ops_valid <= 1'b0;
            op_idx_o  <= '0;
          end else if (key_valid && key_code == KEY_CLEAR) begin
            state     <= ENTRY;
            ops_valid <= 1'b0;
            op_idx_o  <= '0;
            for (int k = 0; k < NUM_OPS; k++) slots[k] <= '0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule
